ttl74169_counter: RTL and testbench
===================================

// Module: ttl74169_counter
// PURPOSE
//   Synchronous up/down binary counter with parallel load, modelled on the 74LS169.
//   Two enables (enp_n, ent_n) and a ripple-carry output (rco_n) let instances cascade
//   into wider counters.
//   Typical use: two instances form the 8-bit horizontal video counter.
//   Loading with P=4'h0 (low nibble) and P=4'hC (high nibble) gives a 0xC0..0xFF count cycle.
// PARAMETERS
//   WIDTH  4  counter width in bits; the 74LS169 equivalent is WIDTH=4
// PORTS
//   clk        in   1      clock; all state changes on the rising edge
//   rst        in   1      reset; synchronous, active-high
//   direction  in   1      1 = count up, 0 = count down
//   load_n     in   1      active-low synchronous parallel load
//   enp_n      in   1      active-low count enable P; does not affect rco_n
//   ent_n      in   1      active-low count enable T; also gates rco_n
//   P          in   WIDTH  parallel load data
//   Q          out  WIDTH  counter value (registered)
//   rco_n      out  1      active-low ripple carry/borrow (combinational)
// BEHAVIOUR
//   Interface: one clock (clk); synchronous active-high reset (rst).
//   - Rising-edge priority, highest first:
//       1. rst=1: Q <= 0.
//       2. load_n=0: Q <= P. Enables and direction are ignored.
//       3. enp_n=0 and ent_n=0: count one step.
//          direction=1: Q <= Q+1, wrapping from all-ones to 0.
//          direction=0: Q <= Q-1, wrapping from 0 to all-ones.
//       4. Otherwise Q holds.
//   - Arithmetic is modulo 2^WIDTH; there is no saturation.
//   - rco_n is combinational from Q, direction and ent_n, with no clock latency:
//       rco_n = ~( ~ent_n & ( (direction & Q==all-ones) | (~direction & Q==0) ) ).
//     enp_n and load_n do not affect rco_n.
//   - While Q sits at the terminal value, rco_n stays low for the whole cycle.
//     It rises on the edge that wraps, loads or resets Q.
//   - Reset value: Q=0.
//     After reset, rco_n=1 when direction=1.
//     After reset, rco_n=ent_n when direction=0.
//   - Simultaneous events:
//       rst with load_n=0: rst wins.
//       load_n=0 with both enables active: load wins (no increment on that edge).
//   - Changing direction mid-count takes effect on the next edge.
//     rco_n re-evaluates immediately for the new direction.
//   - Cascading: connect the lower rco_n to both enables (enp_n, ent_n) of the upper instance.
//     The upper stage then steps exactly on the edge where the lower stage wraps.
//   - Latency: one clock from inputs to Q, zero from Q to rco_n.
//   - No X-propagation from Q after reset.
//   - Outputs carry no # delays in RTL.
// TESTING
//   1. Reset: rst=1, one edge.
//      -> Q=0; with direction=1, rco_n=1.
//      Release rst; ent_n=0, direction=0 -> rco_n=0.
//   2. Load and count up: P=4'hC, load_n=0 for one edge -> Q=C.
//      Then load_n=1, enables=0, direction=1 -> Q=D, E, F.
//      rco_n=0 only while Q=F; next edge Q=0, rco_n=1.
//   3. Count down with wrap: load P=4'h1, direction=0 -> Q=0 with rco_n=0.
//      Next edge Q=F, rco_n=1.
//   4. Enables: enp_n=1 or ent_n=1 -> Q holds for 5 edges.
//      With ent_n=1 at Q=F, rco_n=1.
//      With enp_n=1, ent_n=0 at Q=F, rco_n=0.
//   5. Priority:
//      rst=1 with load_n=0 and P=A -> Q=0.
//      load_n=0 with enables active and P=5 -> Q=5, not 6.
//   6. Cascade: two instances; low P=0, high P=C, shared load_n pulse -> 8-bit value 0xC0.
//      Count up 63 edges to 0xFF; upper rco_n=0 only at 0xFF.
//      Next edge -> 0x00.

Source files
------------

// File: rtl/ttl74169_counter.sv
// 74LS169-style synchronous up/down counter with parallel load and cascadable ripple carry.
// Q is registered; rco_n is decoded combinationally from Q, direction and ent_n.
module ttl74169_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             direction,
  input  logic             load_n,
  input  logic             enp_n,
  input  logic             ent_n,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Q,
  output logic             rco_n
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             terminal_c;

  // Next count: load beats counting; both enables are needed to step.
  always_comb begin
    q_d = q_q;
    if (!load_n) begin
      q_d = P;
    end else if (!enp_n && !ent_n) begin
      q_d = direction ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Terminal count depends on direction: all-ones going up, zero going down.
  assign terminal_c = direction ? (q_q == {WIDTH{1'b1}}) : (q_q == '0);
  assign rco_n      = ~(~ent_n & terminal_c);
  assign Q          = q_q;

endmodule

// File: tb/tb_ttl74169_counter.sv
// Self-checking bench: directed scenarios plus randomized traffic against an arithmetic model,
// for a single 4-bit counter and an 8-bit cascade of two instances.
module tb_ttl74169_counter;

  logic       clk;
  logic       rst, direction, load_n, enp_n, ent_n;
  logic [3:0] P, Q;
  logic       rco_n;

  logic       c_rst, c_dir, c_load_n, c_en_n;
  logic [7:0] c_p;
  logic [3:0] lo_q, hi_q;
  logic       lo_rco_n, hi_rco_n;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  int m_q = 0;   // model of single counter, 0..15
  int m_c = 0;   // model of cascaded 8-bit value, 0..255

  ttl74169_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .direction(direction), .load_n(load_n),
    .enp_n(enp_n), .ent_n(ent_n), .P(P), .Q(Q), .rco_n(rco_n)
  );

  ttl74169_counter #(.WIDTH(4)) u_lo (
    .clk(clk), .rst(c_rst), .direction(c_dir), .load_n(c_load_n),
    .enp_n(c_en_n), .ent_n(c_en_n), .P(c_p[3:0]), .Q(lo_q), .rco_n(lo_rco_n)
  );

  ttl74169_counter #(.WIDTH(4)) u_hi (
    .clk(clk), .rst(c_rst), .direction(c_dir), .load_n(c_load_n),
    .enp_n(lo_rco_n), .ent_n(lo_rco_n), .P(c_p[7:4]), .Q(hi_q), .rco_n(hi_rco_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Carry is active when enabled and sitting at the terminal value of an N-state counter.
  function automatic logic rco_model(int q, int modulus, logic dir, logic en_n);
    logic term;
    term = dir ? (q == modulus - 1) : (q == 0);
    return !(!en_n && term);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: modulo arithmetic on integers.
  always @(posedge clk) begin
    if (rst)                     m_q <= 0;
    else if (!load_n)            m_q <= int'(P);
    else if (!enp_n && !ent_n)   m_q <= direction ? (m_q + 1) % 16 : (m_q + 15) % 16;

    if (c_rst)                   m_c <= 0;
    else if (!c_load_n)          m_c <= int'(c_p);
    else if (!c_en_n)            m_c <= c_dir ? (m_c + 1) % 256 : (m_c + 255) % 256;
  end

  // Continuous comparison away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("q",          32'(Q),              32'(m_q));
      check("rco_n",      32'(rco_n),          32'(rco_model(m_q, 16, direction, ent_n)));
      check("casc_q",     32'({hi_q, lo_q}),   32'(m_c));
      check("casc_rco_n", 32'(hi_rco_n),       32'(rco_model(m_c, 256, c_dir, c_en_n)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Hand-computed expectations pin both the DUT and the model.
  task automatic expect_q(string name, int exp_q, logic exp_rco);
    check({name, "_q"},     32'(Q),     32'(exp_q));
    check({name, "_rco_n"}, 32'(rco_n), 32'(exp_rco));
    check({name, "_model"}, 32'(m_q),   32'(exp_q));
  endtask

  initial begin
    rst = 1'b1; direction = 1'b1; load_n = 1'b1; enp_n = 1'b1; ent_n = 1'b1; P = 4'h0;
    c_rst = 1'b1; c_dir = 1'b1; c_load_n = 1'b1; c_en_n = 1'b1; c_p = 8'h00;

    // Reset
    tick();
    chk_en = 1'b1;
    expect_q("reset", 0, 1'b1);
    rst = 1'b0; ent_n = 1'b0; direction = 1'b0;
    #1;
    expect_q("reset_down", 0, 1'b0);

    // Load C then count up through the wrap
    P = 4'hC; load_n = 1'b0; direction = 1'b1;
    tick(); expect_q("load_c", 12, 1'b1);
    load_n = 1'b0; load_n = 1'b1; enp_n = 1'b0; ent_n = 1'b0;
    tick(); expect_q("up_d", 13, 1'b1);
    tick(); expect_q("up_e", 14, 1'b1);
    tick(); expect_q("up_f", 15, 1'b0);
    tick(); expect_q("up_wrap", 0, 1'b1);

    // Count down with wrap
    P = 4'h1; load_n = 1'b0; direction = 1'b0;
    tick(); expect_q("load_1", 1, 1'b1);
    load_n = 1'b1;
    tick(); expect_q("down_0", 0, 1'b0);
    tick(); expect_q("down_wrap", 15, 1'b1);

    // Enables hold the count; only ent_n gates the carry
    direction = 1'b1; enp_n = 1'b1; ent_n = 1'b0;
    #1; expect_q("hold_p", 15, 1'b0);
    repeat (5) tick();
    expect_q("hold_p5", 15, 1'b0);
    enp_n = 1'b0; ent_n = 1'b1;
    #1; expect_q("hold_t", 15, 1'b1);
    repeat (5) tick();
    expect_q("hold_t5", 15, 1'b1);

    // Priority: reset over load, load over count
    rst = 1'b1; load_n = 1'b0; P = 4'hA; enp_n = 1'b0; ent_n = 1'b0;
    tick(); expect_q("rst_over_load", 0, 1'b1);
    rst = 1'b0; P = 4'h5;
    tick(); expect_q("load_over_cnt", 5, 1'b1);
    load_n = 1'b1;
    tick(); expect_q("after_load", 6, 1'b1);

    // Cascade: 0xC0 .. 0xFF, then wrap to 0x00
    c_rst = 1'b0; c_load_n = 1'b0; c_p = 8'hC0; c_dir = 1'b1; c_en_n = 1'b0;
    tick();
    check("casc_load", 32'({hi_q, lo_q}), 32'h0000_00C0);
    c_load_n = 1'b1;
    repeat (63) tick();
    check("casc_ff",     32'({hi_q, lo_q}), 32'h0000_00FF);
    check("casc_ff_rco", 32'(hi_rco_n),     32'h0);
    tick();
    check("casc_wrap",     32'({hi_q, lo_q}), 32'h0000_0000);
    check("casc_wrap_rco", 32'(hi_rco_n),     32'h1);

    // Randomized traffic on both counters
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      load_n    = ($urandom_range(0, 9) != 0);
      direction = 1'($urandom_range(0, 1));
      enp_n     = ($urandom_range(0, 4) == 0);
      ent_n     = ($urandom_range(0, 4) == 0);
      P         = 4'($urandom_range(0, 15));
      c_rst     = ($urandom_range(0, 99) == 0);
      c_load_n  = ($urandom_range(0, 29) != 0);
      c_dir     = ($urandom_range(0, 7) == 0) ? ~c_dir : c_dir;
      c_en_n    = ($urandom_range(0, 9) == 0);
      c_p       = 8'($urandom_range(0, 255));
      tick();
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
